// File: rtl/rom_loader.sv
// rom_loader: boot-time copy of the ROM image from SPI configuration flash into board SRAM.
// Owns the SRAM bus through the arbiter's loader port group until the image is fully copied.
// Optional feature macro: LOADER_FAST_READ_EN selects the fast-read opcode (8'h0B) and adds
// eight dummy SCK cycles between the command and the data; otherwise plain read (8'h03).

module rom_loader #(
    parameter logic [23:0] FLASH_OFFSET = 24'h180000,
    parameter logic [20:0] DEST_BASE    = 21'h100000,
    parameter logic [20:0] LOAD_LEN     = 21'h040000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reload,
    output logic        loader_act,
    output logic [20:0] loader_a,
    output logic [7:0]  loader_d,
    output logic        loader_wr,
    output logic        done,
    output logic        flash_ncs,
    output logic        flash_sck,
    output logic        flash_mosi,
    input  logic        flash_miso
);

`ifdef LOADER_FAST_READ_EN
    localparam logic [7:0] OPCODE = 8'h0B;
`else
    localparam logic [7:0] OPCODE = 8'h03;
`endif

    typedef enum logic [2:0] {
        StCsSetup,
        StCmd,
        StDummy,
        StData,
        StWrite,
        StFinish,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic        setup_q, setup_d;      // second CS_SETUP clock (chip select already low)
    logic        phase_q, phase_d;      // 0: SCK low phase, 1: SCK high phase
    logic [4:0]  bit_cnt_q, bit_cnt_d;  // bits left in the current SPI field, minus one
    logic [31:0] cmd_sh_q, cmd_sh_d;
    logic [6:0]  rx_q, rx_d;            // first seven bits of the byte being received
    logic [1:0]  wr_cnt_q, wr_cnt_d;
    logic [20:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [20:0] count_q, count_d;
    logic        miso_sync_q;

    // MISO resynchroniser; the flash changes MISO on the SCK fall, so one register is enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miso_sync_q <= 1'b0;
        end else begin
            miso_sync_q <= flash_miso;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StCsSetup;
            setup_q   <= 1'b0;
            phase_q   <= 1'b0;
            bit_cnt_q <= 5'd0;
            cmd_sh_q  <= 32'd0;
            rx_q      <= 7'd0;
            wr_cnt_q  <= 2'd0;
            addr_q    <= DEST_BASE;
            data_q    <= 8'd0;
            count_q   <= 21'd0;
        end else begin
            state_q   <= state_d;
            setup_q   <= setup_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            cmd_sh_q  <= cmd_sh_d;
            rx_q      <= rx_d;
            wr_cnt_q  <= wr_cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            count_q   <= count_d;
        end
    end

    // Next-state and datapath update; each SPI bit is an L phase followed by an H phase.
    always_comb begin
        state_d   = state_q;
        setup_d   = setup_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        cmd_sh_d  = cmd_sh_q;
        rx_d      = rx_q;
        wr_cnt_d  = wr_cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        count_d   = count_q;

        unique case (state_q)
            StCsSetup: begin
                if (!setup_q) begin
                    setup_d = 1'b1;
                end else begin
                    state_d   = StCmd;
                    phase_d   = 1'b0;
                    bit_cnt_d = 5'd31;
                    cmd_sh_d  = {OPCODE, FLASH_OFFSET};
                end
            end
            StCmd: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d  = 1'b0;
                    cmd_sh_d = {cmd_sh_q[30:0], 1'b0};
                    if (bit_cnt_q == 5'd0) begin
                        bit_cnt_d = 5'd7;
`ifdef LOADER_FAST_READ_EN
                        state_d   = StDummy;
`else
                        state_d   = StData;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end
                end
            end
            StDummy: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (bit_cnt_q == 5'd0) begin
                        bit_cnt_d = 5'd7;
                        state_d   = StData;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end
                end
            end
            StData: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    // Sample at the end of the H phase from the synchronised copy.
                    phase_d = 1'b0;
                    rx_d    = {rx_q[5:0], miso_sync_q};
                    if (bit_cnt_q == 5'd0) begin
                        data_d   = {rx_q, miso_sync_q};
                        wr_cnt_d = 2'd0;
                        state_d  = StWrite;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end
                end
            end
            StWrite: begin
                if (wr_cnt_q != 2'd2) begin
                    wr_cnt_d = wr_cnt_q + 2'd1;
                end else begin
                    count_d = count_q + 21'd1;
                    addr_d  = addr_q + 21'd1;
                    if ((count_q + 21'd1) == LOAD_LEN) begin
                        state_d = StFinish;
                    end else begin
                        // Chip select stays low: the flash keeps streaming the next byte.
                        state_d   = StData;
                        phase_d   = 1'b0;
                        bit_cnt_d = 5'd7;
                    end
                end
            end
            StFinish: begin
                state_d = StDone;
            end
            StDone: begin
                if (reload) begin
                    state_d = StCsSetup;
                    setup_d = 1'b0;
                    phase_d = 1'b0;
                    count_d = 21'd0;
                    addr_d  = DEST_BASE;
                    data_d  = 8'd0;
                end
            end
            default: begin
                state_d = StCsSetup;
            end
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        loader_act = (state_q != StDone);
        done       = (state_q == StDone);
        flash_ncs  = 1'b0;
        flash_sck  = 1'b0;
        flash_mosi = 1'b0;
        loader_wr  = 1'b0;
        unique case (state_q)
            StCsSetup: flash_ncs = !setup_q;
            StCmd: begin
                flash_sck  = phase_q;
                flash_mosi = cmd_sh_q[31];
            end
            StDummy, StData: flash_sck = phase_q;
            StWrite:          loader_wr = (wr_cnt_q == 2'd1);
            StFinish, StDone: flash_ncs = 1'b1;
            default:          flash_ncs = 1'b1;
        endcase
    end

    assign loader_a = addr_q;
    assign loader_d = data_q;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: SPI flash models plus an SRAM write scoreboard.
// Instance 0 copies 16 bytes to the default base; instance 1 copies 4 bytes across the
// 21-bit address wrap. LOADER_FAST_READ_EN switches the expected opcode and timing.

module tb_rom_loader;

    localparam logic [23:0] FLASH_OFFSET = 24'h180000;
    localparam logic [20:0] DEST0        = 21'h100000;
    localparam logic [20:0] DEST1        = 21'h1FFFFE;
    localparam int          LIMIT        = 2000;
`ifdef LOADER_FAST_READ_EN
    localparam logic [7:0] OPC      = 8'h0B;
    localparam int         HDR_BITS = 40;
    localparam int         EXP_T    = 2 + 64 + 16 + 19 * 16 + 1;
`else
    localparam logic [7:0] OPC      = 8'h03;
    localparam int         HDR_BITS = 32;
    localparam int         EXP_T    = 2 + 64 + 19 * 16 + 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        reload0;
    logic        act  [2];
    logic        wr   [2];
    logic        dn   [2];
    logic        ncs  [2];
    logic        sck  [2];
    logic        mosi [2];
    logic        miso [2];
    logic [20:0] la0, la1;
    logic [7:0]  ld0, ld1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rom_loader #(
        .FLASH_OFFSET (FLASH_OFFSET),
        .DEST_BASE    (DEST0),
        .LOAD_LEN     (21'd16)
    ) dut0 (
        .clk        (clk),
        .reset      (reset),
        .reload     (reload0),
        .loader_act (act[0]),
        .loader_a   (la0),
        .loader_d   (ld0),
        .loader_wr  (wr[0]),
        .done       (dn[0]),
        .flash_ncs  (ncs[0]),
        .flash_sck  (sck[0]),
        .flash_mosi (mosi[0]),
        .flash_miso (miso[0])
    );

    rom_loader #(
        .FLASH_OFFSET (FLASH_OFFSET),
        .DEST_BASE    (DEST1),
        .LOAD_LEN     (21'd4)
    ) dut1 (
        .clk        (clk),
        .reset      (reset),
        .reload     (1'b0),
        .loader_act (act[1]),
        .loader_a   (la1),
        .loader_d   (ld1),
        .loader_wr  (wr[1]),
        .done       (dn[1]),
        .flash_ncs  (ncs[1]),
        .flash_sck  (sck[1]),
        .flash_mosi (mosi[1]),
        .flash_miso (miso[1])
    );

    // Flash model: byte at address FLASH_OFFSET + k holds k[7:0]; mode 0, output on SCK fall.
    for (genvar g = 0; g < 2; g++) begin : g_flash
        int unsigned pos_cnt   = 0;
        int unsigned out_cnt   = 0;
        int unsigned cmd_count = 0;
        logic [31:0] cmd_sh    = '0;
        logic [31:0] cmd_last  = '0;
        logic        dummy_bad = 1'b0;

        always @(posedge sck[g] or posedge ncs[g]) begin
            if (ncs[g]) begin
                pos_cnt <= 0;
            end else begin
                if (pos_cnt < 32) cmd_sh <= {cmd_sh[30:0], mosi[g]};
                if (pos_cnt == 31) begin
                    cmd_last  <= {cmd_sh[30:0], mosi[g]};
                    cmd_count <= cmd_count + 1;
                end
                if (pos_cnt >= 32 && pos_cnt < HDR_BITS && mosi[g]) dummy_bad <= 1'b1;
                pos_cnt <= pos_cnt + 1;
            end
        end

        always @(negedge sck[g] or posedge ncs[g]) begin
            logic [23:0] fa;
            logic [7:0]  fb;
            if (ncs[g]) begin
                out_cnt <= 0;
                miso[g] <= 1'b0;
            end else if (pos_cnt >= HDR_BITS) begin
                fa = cmd_sh[23:0] + 24'(out_cnt / 8);
                fb = 8'(fa - FLASH_OFFSET);
                miso[g] <= fb[7 - (out_cnt % 8)];
                out_cnt <= out_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard of expected {address, data} writes for instance 0, and its SRAM image.
    logic [28:0] sb [$];
    logic [28:0] sb_exp;
    logic [7:0]  sram0 [int];
    int          pulses0   = 0;
    logic        prev_wr   = 1'b0;
    logic        post_pend = 1'b0;
    logic [20:0] prev_a, post_a;
    logic [7:0]  prev_d, post_d;

    always @(negedge clk) begin
        if (reset) begin
            post_pend = 1'b0;
            prev_wr   = 1'b0;
        end else begin
            if (wr[0]) begin
                chk("wr_single_cycle", 64'(prev_wr), 64'd0);
                chk("wr_needs_act", 64'(act[0]), 64'd1);
                chk("pre_stable", {prev_a, prev_d}, {la0, ld0});
                if (sb.size() == 0) begin
                    chk("sb_unexpected_write", 64'(sb.size()), 64'd1);
                end else begin
                    sb_exp = sb.pop_front();
                    chk("write", {la0, ld0}, 64'(sb_exp));
                end
                sram0[int'(la0)] = ld0;
                pulses0++;
                post_pend = 1'b1;
                post_a    = la0;
                post_d    = ld0;
            end else if (post_pend) begin
                chk("post_stable", {la0, ld0}, {post_a, post_d});
                post_pend = 1'b0;
            end
            prev_wr = wr[0];
            prev_a  = la0;
            prev_d  = ld0;
        end
    end

    logic [20:0] wa1 [$];
    logic [7:0]  wd1 [$];
    always @(negedge clk) begin
        if (!reset && wr[1]) begin
            wa1.push_back(la1);
            wd1.push_back(ld1);
        end
    end

    task automatic push_expected();
        sb.delete();
        for (int i = 0; i < 16; i++) sb.push_back({DEST0 + 21'(i), 8'(i)});
    endtask

    task automatic check_sram(input string tag);
        int          k;
        logic [7:0]  v;
        chk({tag, "_count"}, 64'(sram0.num()), 64'd16);
        for (int i = 0; i < 16; i++) begin
            k = int'(DEST0) + i;
            v = sram0.exists(k) ? sram0[k] : 8'hxx;
            chk(tag, {k, v}, {k, 8'(i)});
        end
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    // Counts rising edges until done; optionally pulses reload after edge number reload_at.
    task automatic run_to_done(input int start, input int reload_at, output int n);
        n = start;
        while (!dn[0] && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
            reload0 = (n == reload_at);
        end
        reload0 = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base_p;
        int base_cmd;
        logic [20:0] wrap_a [4];
        wrap_a = '{21'h1FFFFE, 21'h1FFFFF, 21'h000000, 21'h000001};

        // Reset values.
        reset   = 1'b1;
        reload0 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_act", 64'(act[0]), 64'd1);
        chk("rst_done", 64'(dn[0]), 64'd0);
        chk("rst_ncs", 64'(ncs[0]), 64'd1);
        chk("rst_sck", 64'(sck[0]), 64'd0);
        chk("rst_mosi", 64'(mosi[0]), 64'd0);
        chk("rst_wr", 64'(wr[0]), 64'd0);
        chk("rst_a", 64'(la0), 64'(DEST0));
        chk("rst_d", 64'(ld0), 64'd0);
        chk("rst_a_wrapcfg", 64'(la1), 64'(DEST1));

        // Full load, with a reload pulse while busy that must be ignored.
        push_expected();
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ncs_low_first_clock", 64'(ncs[0]), 64'd0);
        run_to_done(1, 200, n);
        chk("done_time", 64'(n), 64'(EXP_T));
        chk("done_act", 64'(act[0]), 64'd0);
        chk("done_ncs", 64'(ncs[0]), 64'd1);
        chk("done_sck", 64'(sck[0]), 64'd0);
        chk("done_last_d", 64'(ld0), 64'h0F);
        chk("cmd_word", 64'(g_flash[0].cmd_last), 64'({OPC, FLASH_OFFSET}));
        chk("pulse_count", 64'(pulses0), 64'd16);
`ifdef LOADER_FAST_READ_EN
        chk("dummy_mosi_low", 64'(g_flash[0].dummy_bad), 64'd0);
`endif
        check_sram("sram_run1");

        // Wrap-around instance.
        chk("wrap_done", 64'(dn[1]), 64'd1);
        chk("wrap_count", 64'(wa1.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wa1.size()) chk("wrap_write", {wa1[i], wd1[i]}, {wrap_a[i], 8'(i)});
        end

        // Asynchronous reset in the middle of byte 7, then a restarted load.
        base_cmd = g_flash[0].cmd_count;
        reset = 1'b1;
        @(negedge clk);
        sram0.delete();
        push_expected();
        base_p = pulses0;
        reset = 1'b0;
        n = 0;
        while (pulses0 < base_p + 6 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("reached_byte7", 64'(pulses0), 64'(base_p + 6));
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_ncs", 64'(ncs[0]), 64'd1);
        chk("async_wr", 64'(wr[0]), 64'd0);
        chk("async_sck", 64'(sck[0]), 64'd0);
        chk("async_act", 64'(act[0]), 64'd1);
        chk("async_a", 64'(la0), 64'(DEST0));
        @(negedge clk);
        push_expected();
        reset = 1'b0;
        run_to_done(0, -1, n);
        chk("done_time_after_reset", 64'(n), 64'(EXP_T));
        chk("cmd_reissued", 64'(g_flash[0].cmd_count - base_cmd), 64'd2);
        check_sram("sram_after_reset");

        // Reload from DONE.
        sram0.delete();
        push_expected();
        @(posedge clk);
        #1 reload0 = 1'b1;
        @(posedge clk);
        #1 reload0 = 1'b0;
        chk("reload_act", 64'(act[0]), 64'd1);
        chk("reload_done", 64'(dn[0]), 64'd0);
        chk("reload_a", 64'(la0), 64'(DEST0));
        chk("reload_ncs", 64'(ncs[0]), 64'd1);
        run_to_done(0, -1, n);
        chk("done_time_reload", 64'(n), 64'(EXP_T));
        check_sram("sram_reload");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
# rom_loader

Boot-time loader that streams the ROM image from the external SPI configuration flash into the board SRAM before the CPU runs. It sits directly upstream of the memory arbiter and drives its `loader_act` / `loader_a` / `loader_d` / `loader_wr` port group. While `loader_act` is high, the arbiter hands the SRAM bus entirely to this block. On completion it releases the bus and the CPU/video paths take over.

## Interface
Parameters:
- `FLASH_OFFSET`, 24'h180000: first flash byte address of the image.
- `DEST_BASE`, 21'h100000: first SRAM address written (ROM window base).
- `LOAD_LEN`, 21'h040000: number of bytes copied (256 KB = 4 banks x 4 pages x 16 KB).

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high; restarts the load from scratch.
- `reload` in 1: single-cycle pulse; restarts the load when in DONE, ignored otherwise.
- `loader_act` out 1: SRAM bus owned by loader.
- `loader_a` out 21: SRAM address.
- `loader_d` out 8: SRAM write data.
- `loader_wr` out 1: SRAM write strobe, active-high.
- `done` out 1: image fully copied.
- `flash_ncs` out 1: flash chip select, active-low.
- `flash_sck` out 1: SPI clock, mode 0.
- `flash_mosi` out 1: SPI data to flash.
- `flash_miso` in 1: SPI data from flash; synchronised through one register inside the block.

## Operation
- States: CS_SETUP -> CMD -> (DUMMY) -> DATA -> WRITE -> DATA ... -> FINISH -> DONE.
- Reset values: `loader_act`=1, `done`=0, `flash_ncs`=1, `flash_sck`=0, `flash_mosi`=0, `loader_wr`=0, `loader_a`=`DEST_BASE`, `loader_d`=0, byte counter=0; state CS_SETUP.
- CS_SETUP: `flash_ncs` goes 0 on the first clock after reset release; stays 2 clocks, then CMD.
- CMD: shifts 32 bits MSB first: read opcode 8'h03, then `FLASH_OFFSET`[23:0].
- DATA: shifts in 8 bits MSB first into a shift register; then WRITE.
- WRITE: 3 clocks with SCK held low and `loader_d`/`loader_a` stable.
  - Clock 1: `loader_d` = byte, `loader_wr`=0.
  - Clock 2: `loader_wr`=1.
  - Clock 3: `loader_wr`=0.
  - At exit, the byte counter increments and `loader_a` increments (21-bit wrap).
  - If the counter reaches `LOAD_LEN`, go to FINISH; otherwise go to DATA. `flash_ncs` stays low, so the flash auto-increments.
- FINISH: `flash_ncs`=1 and `flash_sck`=0 for one clock. Then DONE: `loader_act`=0, `done`=1, `loader_wr`=0. `loader_a` and `loader_d` hold their last values.
- `reload` in DONE: same effect as reset, except synchronous. Next clock: `loader_act`=1, `done`=0, counter=0, `loader_a`=`DEST_BASE`, state CS_SETUP.
- `reset` mid-transfer: outputs return to reset values immediately (async). The partial SRAM contents are simply overwritten by the restarted load.
- `loader_wr` is never high while `loader_act` is low, and never high in two consecutive clocks.

## Timing
- Each SPI bit takes 2 clocks (SCK = clk/2):
  - Phase L: `flash_sck`=0, `flash_mosi` updated at entry.
  - Phase H: `flash_sck`=1.
- MISO is sampled from the synchronised copy on the clock edge ending phase H.
- The synchroniser delay is covered because the flash output changes on the SCK fall. The sample uses the value registered one clock after the rise.
- Per-byte cost: 16 SPI clocks + 3 write clocks = 19 clocks.
- Total load time: 2 + 64 (+16 fast) + 19 x `LOAD_LEN` + 1 clocks from reset release to `done`=1.
- `done` and `loader_act` change in the same clock edge.

## Configuration
- `LOADER_FAST_READ_EN` defined: opcode 8'h0B, with a DUMMY state of 8 SCK cycles (`flash_mosi`=0, MISO ignored) between CMD and DATA. Total time grows by 16 clocks.
- `LOADER_FAST_READ_EN` undefined: opcode 8'h03, no DUMMY state.

## Test plan
- Reset, flash model holding bytes 8'h00..8'hFF repeating at `FLASH_OFFSET`, `LOAD_LEN`=16 -> MOSI stream 8'h03,8'h18,8'h00,8'h00. SRAM model then holds addresses 21'h100000..21'h10000F = 8'h00..8'h0F, with `done`=1 at clock 2+64+304+1.
- Same run, checking write strobes -> exactly 16 single-clock `loader_wr` pulses, with `loader_a`/`loader_d` stable one clock before and after each pulse.
- Assert `reset` during byte 7 -> `flash_ncs`=1 and `loader_wr`=0 immediately. After release, the command is reissued and the SRAM ends identical to an uninterrupted run.
- `reload` pulse while busy -> ignored, completion timing unchanged. `reload` pulse in DONE -> `loader_act`=1 next clock and a full reload.
- `DEST_BASE`=21'h1FFFFE, `LOAD_LEN`=4 -> writes land at 21'h1FFFFE, 21'h1FFFFF, 21'h000000, 21'h000001.
- With `LOADER_FAST_READ_EN` -> opcode 8'h0B and 8 dummy SCK cycles; the data matches the first scenario and `done` arrives 16 clocks later.
